// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the dma_arb slot-arbitrated DMA engine.
package dma_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_GAP  = 3'd3,
      ST_FIN  = 3'd4
   } state_e;

   localparam logic [2:0] REG_SRC_L  = 3'd0;
   localparam logic [2:0] REG_SRC_H  = 3'd1;
   localparam logic [2:0] REG_DST_L  = 3'd2;
   localparam logic [2:0] REG_DST_H  = 3'd3;
   localparam logic [2:0] REG_LEN_L  = 3'd4;
   localparam logic [2:0] REG_LEN_H  = 3'd5;
   localparam logic [2:0] REG_CTRL   = 3'd6;
   localparam logic [2:0] REG_STATUS = 3'd7;

   localparam int CTRL_START     = 0;
   localparam int CTRL_IRQ_EN    = 1;
   localparam int CTRL_FIXED_SRC = 2;
   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 7;

   // Slots in which the CPU may use the bus.
   function automatic logic cpu_owns(state_e s);
      return (s == ST_IDLE) || (s == ST_GAP) || (s == ST_FIN);
   endfunction

endpackage

// File: rtl/dma_arb_slot_ticker.sv
// Bus slot timer: counts clk modulo CLKDIV and pulses slot_tick on the last clk of each slot.
module slot_ticker #(
   parameter int CLKDIV = 4
) (
   input  logic                      clk,
   input  logic                      resb,
   output logic                      slot_tick,
   output logic [$clog2(CLKDIV)-1:0] count
);

   localparam int            CW   = $clog2(CLKDIV);
   localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

   logic [CW-1:0] count_q, count_d;

   assign slot_tick = (count_q == LAST);
   assign count     = count_q;

   always_comb begin
      count_d = slot_tick ? '0 : count_q + CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments; reset is in the sensitivity list (async).
   always_ff @(posedge clk or negedge resb) begin
      if (!resb) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/dma_arb.sv
// Slot-arbitrated byte-copy DMA sharing a RAM port with a CPU. Build option:
// DMA_FAIR_SLOT_EN inserts a CPU-owned GAP slot after every non-final write.
module dma_arb
   import dma_arb_pkg::*;
#(
   parameter int          CLKDIV   = 4,
   parameter logic [15:0] REG_BASE = 16'h8810
) (
   input  logic        clk,
   input  logic        resb,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_we,
   output logic        slot_tick,
   output logic        cpu_en,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_dout,
   output logic        mem_we,
   input  logic [7:0]  mem_din,
   output logic [7:0]  reg_dout,
   output logic        irq_n,
   output logic        busy
);

   localparam int CW = $clog2(CLKDIV);

   logic [CW-1:0] slot_count;
   state_e        state_q, state_d;
   logic [15:0]   src_q, src_d, dst_q, dst_d, len_q, len_d;
   logic          irq_en_q, irq_en_d, fixed_src_q, fixed_src_d;
   logic          busy_q, busy_d, done_q, done_d, irq_n_q, irq_n_d;
   logic [7:0]    data_q, data_d, reg_dout_q, reg_dout_d, status_byte;
   logic [2:0]    reg_off;
   logic          reg_hit, reg_wr, reg_rd, start, dma_go, wr_step, last_wr, done_set;

   slot_ticker #(.CLKDIV(CLKDIV)) u_slot_ticker (
      .clk       (clk),
      .resb      (resb),
      .slot_tick (slot_tick),
      .count     (slot_count)
   );

   assign reg_off  = cpu_addr[2:0];
   assign reg_hit  = cpu_en && (cpu_addr[15:3] == REG_BASE[15:3]);
   assign reg_wr   = reg_hit && cpu_we && !busy_q;
   assign reg_rd   = reg_hit && !cpu_we;
   assign start    = reg_wr && (reg_off == REG_CTRL) && cpu_dout[CTRL_START];
   assign dma_go   = start && (len_q != '0);
   assign wr_step  = (state_q == ST_WR) && slot_tick;
   assign last_wr  = wr_step && (len_q == 16'd1);
   assign done_set = (start && len_q == '0) || last_wr;

   assign busy     = busy_q;
   assign irq_n    = irq_n_q;
   assign reg_dout = reg_dout_q;

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (dma_go) state_d = ST_RD;
         ST_RD:   if (slot_tick) state_d = ST_WR;
         ST_WR:
            if (slot_tick) begin
               if (len_q == 16'd1) state_d = ST_FIN;
`ifdef DMA_FAIR_SLOT_EN
               else                state_d = ST_GAP;
`else
               else                state_d = ST_RD;
`endif
            end
         ST_GAP:  if (slot_tick) state_d = ST_RD;
         ST_FIN:  if (slot_tick) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cpu_en   = slot_tick && cpu_owns(state_q);
      mem_addr = cpu_addr;
      mem_dout = cpu_dout;
      mem_we   = cpu_we && cpu_en;
      case (state_q)
         ST_RD: begin
            mem_addr = src_q;
            mem_we   = 1'b0;
         end
         ST_WR: begin
            mem_addr = dst_q;
            mem_dout = data_q;
            mem_we   = slot_tick;
         end
         default: ;
      endcase
   end

   always_comb begin
      src_d       = src_q;
      dst_d       = dst_q;
      len_d       = len_q;
      irq_en_d    = irq_en_q;
      fixed_src_d = fixed_src_q;
      data_d      = data_q;
      busy_d      = busy_q;
      reg_dout_d  = reg_dout_q;

      status_byte            = '0;
      status_byte[STAT_BUSY] = busy_q;
      status_byte[STAT_DONE] = done_q;

      if (reg_wr) begin
         case (reg_off)
            REG_SRC_L: src_d[7:0]  = cpu_dout;
            REG_SRC_H: src_d[15:8] = cpu_dout;
            REG_DST_L: dst_d[7:0]  = cpu_dout;
            REG_DST_H: dst_d[15:8] = cpu_dout;
            REG_LEN_L: len_d[7:0]  = cpu_dout;
            REG_LEN_H: len_d[15:8] = cpu_dout;
            REG_CTRL: begin
               irq_en_d    = cpu_dout[CTRL_IRQ_EN];
               fixed_src_d = cpu_dout[CTRL_FIXED_SRC];
            end
            default: ;
         endcase
      end

      if (wr_step) begin
         dst_d = dst_q + 16'd1;
         if (!fixed_src_q) src_d = src_q + 16'd1;
         len_d = len_q - 16'd1;
      end

      // RAM returns the RD byte in the first clk of the WR slot.
      if ((state_q == ST_WR) && (slot_count == '0)) data_d = mem_din;

      if (dma_go)       busy_d = 1'b1;
      else if (last_wr) busy_d = 1'b0;

      if (done_set)                              done_d = 1'b1;
      else if (reg_rd && reg_off == REG_STATUS)  done_d = 1'b0;
      else                                       done_d = done_q;

      irq_n_d = !(done_d && irq_en_d);

      if (reg_rd) begin
         case (reg_off)
            REG_SRC_L:  reg_dout_d = src_q[7:0];
            REG_SRC_H:  reg_dout_d = src_q[15:8];
            REG_DST_L:  reg_dout_d = dst_q[7:0];
            REG_DST_H:  reg_dout_d = dst_q[15:8];
            REG_LEN_L:  reg_dout_d = len_q[7:0];
            REG_LEN_H:  reg_dout_d = len_q[15:8];
            REG_CTRL:   reg_dout_d = {5'b0, fixed_src_q, irq_en_q, 1'b0};
            default:    reg_dout_d = status_byte;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         irq_en_q    <= 1'b0;
         fixed_src_q <= 1'b0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         irq_n_q     <= 1'b1;
         reg_dout_q  <= '0;
      end else begin
         src_q       <= src_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         irq_en_q    <= irq_en_d;
         fixed_src_q <= fixed_src_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         irq_n_q     <= irq_n_d;
         reg_dout_q  <= reg_dout_d;
      end
   end

endmodule
